// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP transmit engine between four packet sources.
// Define UDP_ARB_PRIO_EN to give source 0 strict priority, with sources 1-3 rotating among themselves.
module udp_tx_arbiter #(
   parameter int          IFG_CYCLES  = 12,
   parameter logic [15:0] MAX_LEN     = 16'd1472,
   parameter logic [15:0] WDOG_CYCLES = 16'd4095
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  src_req,
   input  logic [63:0] src_len,
   input  logic [63:0] src_port,
   input  logic [31:0] src_data,
   output logic [3:0]  src_rd,
   output logic [3:0]  src_grant,
   output logic [3:0]  src_done,
   output logic [3:0]  src_err,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic [15:0] tx_len,
   output logic [15:0] tx_dst_port,
   input  logic        tx_data_req,
   output logic [7:0]  tx_data,
   input  logic        tx_end
);

   typedef enum logic [6:0] {
      IDLE  = 7'b0000001,
      ARB   = 7'b0000010,
      CHECK = 7'b0000100,
      START = 7'b0001000,
      XFER  = 7'b0010000,
      ABORT = 7'b0100000,
      GAP   = 7'b1000000
   } state_t;

   localparam logic [15:0] GAP_LAST  = 16'(IFG_CYCLES - 1);
   localparam logic [15:0] WDOG_LAST = WDOG_CYCLES - 16'd1;

   state_t      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [15:0] len_q, len_d;
   logic [15:0] port_q, port_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [15:0] wdog_q, wdog_d;
   logic [15:0] gap_q, gap_d;
   logic        start_q, start_d;
   logic [3:0]  done_q, done_d;
   logic [3:0]  err_q, err_d;

   logic [2:0]  win;
   logic [1:0]  ptr_after;
   logic        byte_ok;
   logic [15:0] cnt_next;

`ifdef UDP_ARB_PRIO_EN
   localparam logic [1:0] RR_RESET = 2'd1;

   // Source 0 pre-empts; 1-3 rotate, with a pointer of 0 treated as 1.
   function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] base;
      logic [1:0] c;
      pick = 3'b000;
      base = (ptr == 2'd0) ? 2'd0 : ptr - 2'd1;
      for (int k = 2; k >= 0; k--) begin
         c = 2'(((int'(base) + k) % 3) + 1);
         if (req[c]) pick = {1'b1, c};
      end
      if (req[0]) pick = 3'b100;
   endfunction

   function automatic logic [1:0] advance(input logic [1:0] g, input logic [1:0] ptr);
      if (g == 2'd0)      advance = (ptr == 2'd0) ? 2'd1 : ptr;
      else if (g == 2'd3) advance = 2'd1;
      else                advance = g + 2'd1;
   endfunction

   assign ptr_after = advance(idx_q, rr_ptr_q);
`else
   localparam logic [1:0] RR_RESET = 2'd0;

   // First requester at or above the pointer, wrapping 3 -> 0.
   function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] c;
      pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         c = ptr + 2'(k);
         if (req[c]) pick = {1'b1, c};
      end
   endfunction

   assign ptr_after = idx_q + 2'd1;
`endif

   assign win      = pick(src_req, rr_ptr_q);
   assign byte_ok  = (byte_cnt_q < len_q);
   assign cnt_next = byte_cnt_q + {15'd0, (tx_data_req & byte_ok)};

   assign src_rd      = (state_q == XFER && tx_data_req && byte_ok) ? grant_q : 4'b0000;
   assign src_grant   = grant_q;
   assign src_done    = done_q;
   assign src_err     = err_q;
   assign tx_start    = start_q;
   assign tx_len      = len_q;
   assign tx_dst_port = port_q;

   always_comb begin
      tx_data = 8'd0;
      for (int i = 0; i < 4; i++) begin
         if (grant_q[i]) tx_data = tx_data | src_data[8*i +: 8];
      end
   end

   // Next-state logic: pulses default low, everything else holds.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      rr_ptr_d   = rr_ptr_q;
      len_d      = len_q;
      port_d     = port_q;
      byte_cnt_d = byte_cnt_q;
      wdog_d     = wdog_q;
      gap_d      = gap_q;
      start_d    = 1'b0;
      done_d     = 4'b0000;
      err_d      = 4'b0000;
      unique case (state_q)
         IDLE: begin
            if (src_req != 4'b0000) state_d = ARB;
         end
         ARB: begin
            byte_cnt_d = 16'd0;
            wdog_d     = 16'd0;
            if (win[2]) begin
               idx_d   = win[1:0];
               grant_d = 4'b0001 << win[1:0];
               len_d   = src_len[{win[1:0], 4'b0000} +: 16];
               port_d  = src_port[{win[1:0], 4'b0000} +: 16];
               state_d = CHECK;
            end else begin
               state_d = IDLE;
            end
         end
         CHECK: begin
            if (len_q == 16'd0 || len_q > MAX_LEN) begin
               err_d    = grant_q;
               grant_d  = 4'b0000;
               rr_ptr_d = ptr_after;
               gap_d    = 16'd0;
               state_d  = GAP;
            end else begin
               state_d = START;
            end
         end
         START: begin
            if (tx_ready) begin
               start_d = 1'b1;
               wdog_d  = 16'd0;
               state_d = XFER;
            end else begin
               wdog_d = wdog_q + 16'd1;
               if (wdog_q == WDOG_LAST) state_d = ABORT;
            end
         end
         XFER: begin
            byte_cnt_d = cnt_next;
            if (tx_end) begin
               if (cnt_next == len_q) done_d = grant_q;
               else                   err_d  = grant_q;
               grant_d  = 4'b0000;
               rr_ptr_d = ptr_after;
               gap_d    = 16'd0;
               state_d  = GAP;
            end else if (tx_data_req) begin
               wdog_d = 16'd0;
            end else begin
               wdog_d = wdog_q + 16'd1;
               if (wdog_q == WDOG_LAST) state_d = ABORT;
            end
         end
         ABORT: begin
            err_d    = grant_q;
            grant_d  = 4'b0000;
            rr_ptr_d = ptr_after;
            gap_d    = 16'd0;
            state_d  = GAP;
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = 16'd0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         grant_q    <= 4'b0000;
         idx_q      <= 2'd0;
         rr_ptr_q   <= RR_RESET;
         len_q      <= 16'd0;
         port_q     <= 16'd0;
         byte_cnt_q <= 16'd0;
         wdog_q     <= 16'd0;
         gap_q      <= 16'd0;
         start_q    <= 1'b0;
         done_q     <= 4'b0000;
         err_q      <= 4'b0000;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idx_q      <= idx_d;
         rr_ptr_q   <= rr_ptr_d;
         len_q      <= len_d;
         port_q     <= port_d;
         byte_cnt_q <= byte_cnt_d;
         wdog_q     <= wdog_d;
         gap_q      <= gap_d;
         start_q    <= start_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

endmodule
